// File: rtl/dcache_ctrl_if.sv
// CPU-side request/response and line-wide memory bus of the data cache.
// The slave modport is the cache's view; master is the pipeline/memory side.
interface dcache_ctrl_if #(
    parameter int unsigned LINE_W = 256
);
    logic [31:0]       cpu_addr_i;
    logic [31:0]       cpu_data_i;
    logic              cpu_MemRead_i;
    logic              cpu_MemWrite_i;
    logic [31:0]       cpu_data_o;
    logic              cpu_stall_o;
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [31:0]       mem_addr_o;
    logic [LINE_W-1:0] mem_data_o;
    logic [LINE_W-1:0] mem_data_i;
    logic              mem_ack_i;

    modport slave (
        input  cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
        input  mem_data_i, mem_ack_i,
        output cpu_data_o, cpu_stall_o,
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
    );

    modport master (
        output cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
        output mem_data_i, mem_ack_i,
        input  cpu_data_o, cpu_stall_o,
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache with same-cycle hits
// and a stall-the-pipeline miss sequence (optional write-back, then refill).
module dcache_ctrl #(
    parameter int unsigned INDEX_W  = 5,
    parameter int unsigned OFFSET_W = 3,
    parameter int unsigned LINE_W   = 32 << OFFSET_W
) (
    input  logic          clk_i,
    input  logic          rst_i,
    dcache_ctrl_if.slave  bus
);
    localparam int unsigned TAG_W     = 32 - INDEX_W - OFFSET_W - 2;
    localparam int unsigned NUM_LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILLED} state_t;

    state_t state_q, state_d;

    logic [LINE_W-1:0]    data_q  [NUM_LINES];
    logic [TAG_W-1:0]     tag_q   [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;

    logic [TAG_W-1:0]     miss_tag_q, miss_tag_d;
    logic [INDEX_W-1:0]   miss_idx_q, miss_idx_d;

    logic [TAG_W-1:0]     req_tag;
    logic [INDEX_W-1:0]   req_idx;
    logic [OFFSET_W-1:0]  req_off;
    logic                 req, hit, idle_hit, store_hit, refill_ack;
    logic                 unused_addr_lo;

    assign req_tag = bus.cpu_addr_i[31 -: TAG_W];
    assign req_idx = bus.cpu_addr_i[OFFSET_W+2 +: INDEX_W];
    assign req_off = bus.cpu_addr_i[2 +: OFFSET_W];
    assign unused_addr_lo = ^bus.cpu_addr_i[1:0];

    assign req        = bus.cpu_MemRead_i | bus.cpu_MemWrite_i;
    assign hit        = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign idle_hit   = (state_q == IDLE) && hit;
    assign store_hit  = idle_hit && bus.cpu_MemWrite_i;
    assign refill_ack = (state_q == ALLOCATE) && bus.mem_ack_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            miss_tag_q <= miss_tag_d;
            miss_idx_q <= miss_idx_d;
        end
    end

    // Miss address is latched at detection so a withdrawn request still refills the right line.
    always_comb begin
        state_d    = state_q;
        miss_tag_d = miss_tag_q;
        miss_idx_d = miss_idx_q;
        case (state_q)
            IDLE: begin
                if (req && !hit) begin
                    miss_tag_d = req_tag;
                    miss_idx_d = req_idx;
                    state_d    = dirty_q[req_idx] ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: if (bus.mem_ack_i) state_d = ALLOCATE;
            ALLOCATE:  if (bus.mem_ack_i) state_d = REFILLED;
            REFILLED:  state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_enable_o = 1'b0;
        bus.mem_write_o  = 1'b0;
        bus.mem_addr_o   = '0;
        bus.mem_data_o   = '0;
        case (state_q)
            WRITEBACK: begin
                bus.mem_enable_o = 1'b1;
                bus.mem_write_o  = 1'b1;
                bus.mem_addr_o   = {tag_q[miss_idx_q], miss_idx_q, {(OFFSET_W+2){1'b0}}};
                bus.mem_data_o   = data_q[miss_idx_q];
            end
            ALLOCATE: begin
                bus.mem_enable_o = 1'b1;
                bus.mem_addr_o   = {miss_tag_q, miss_idx_q, {(OFFSET_W+2){1'b0}}};
            end
            default: ;
        endcase
        // Reset forces the CPU-facing outputs low even while a request is held.
        bus.cpu_stall_o = rst_i && req && !idle_hit;
        bus.cpu_data_o  = (rst_i && req && idle_hit)
                        ? data_q[req_idx][{req_off, 5'd0} +: 32] : '0;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (refill_ack) begin
            valid_q[miss_idx_q] <= 1'b1;
            dirty_q[miss_idx_q] <= 1'b0;
        end else if (store_hit) begin
            dirty_q[req_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (refill_ack) begin
            data_q[miss_idx_q] <= bus.mem_data_i;
            tag_q[miss_idx_q]  <= miss_tag_q;
        end else if (store_hit) begin
            data_q[req_idx][{req_off, 5'd0} +: 32] <= bus.cpu_data_i;
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a flat CPU-visible memory plus a tag/valid/dirty
// model predict load data, stall lengths and write-back contents.
module tb_dcache_ctrl;
    localparam int unsigned LINE_W = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dcache_ctrl_if #(.LINE_W(LINE_W)) bus ();

    dcache_ctrl #(.INDEX_W(5), .OFFSET_W(3), .LINE_W(LINE_W)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int mem_lat = 3;
    int wb_count = 0;
    logic [31:0]       last_wb_addr = '0;
    logic [LINE_W-1:0] last_wb_line = '0;
    logic [31:0]       last_rd_addr = '0;
    logic [31:0]       last_rdata   = '0;

    logic [LINE_W-1:0] backing [logic [31:0]];
    logic [31:0]       golden  [logic [31:0]];

    bit          m_valid [32];
    bit          m_dirty [32];
    logic [21:0] m_tag   [32];

    task automatic chk(input string name, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [LINE_W-1:0] get_line(input logic [31:0] la);
        logic [LINE_W-1:0] l;
        if (backing.exists(la)) return backing[la];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = 32'hA000_0000 | (la + 32'(w*4));
        return l;
    endfunction

    function automatic logic [31:0] gold_word(input logic [31:0] a);
        logic [31:0] wa;
        logic [LINE_W-1:0] l;
        wa = {a[31:2], 2'b00};
        if (golden.exists(wa)) return golden[wa];
        l = get_line({a[31:5], 5'b0});
        return l[a[4:2]*32 +: 32];
    endfunction

    function automatic logic [LINE_W-1:0] gold_line(input logic [31:0] la);
        logic [LINE_W-1:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = gold_word(la + 32'(w*4));
        return l;
    endfunction

    // Memory: ack arrives in the mem_lat-th cycle of enable; write-backs checked against CPU view.
    int en_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            bus.mem_ack_i = 1'b0;
            en_cnt = 0;
        end else begin
            if (bus.mem_ack_i) begin
                bus.mem_ack_i = 1'b0;
                en_cnt = 0;
            end
            if (bus.mem_enable_o) begin
                en_cnt++;
                if (en_cnt >= mem_lat) begin
                    bus.mem_ack_i = 1'b1;
                    if (bus.mem_write_o) begin
                        chk("wb_line", bus.mem_data_o, gold_line(bus.mem_addr_o));
                        backing[bus.mem_addr_o] = bus.mem_data_o;
                        wb_count++;
                        last_wb_addr = bus.mem_addr_o;
                        last_wb_line = bus.mem_data_o;
                    end else begin
                        bus.mem_data_i = get_line(bus.mem_addr_o);
                        last_rd_addr = bus.mem_addr_o;
                    end
                end
            end
        end
    end

    // Every completing access: loads compared against the flat memory, stores update it.
    always @(negedge clk) begin
        if (rst_n && (bus.cpu_MemRead_i || bus.cpu_MemWrite_i) && !bus.cpu_stall_o) begin
            if (bus.cpu_MemWrite_i)
                golden[{bus.cpu_addr_i[31:2], 2'b00}] = bus.cpu_data_i;
            else
                chk("load_data", {224'd0, bus.cpu_data_o}, {224'd0, gold_word(bus.cpu_addr_i)});
        end
    end

    task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        int exp_stall, cyc;
        logic [4:0] idx;
        bit hit;
        idx = a[9:5];
        hit = m_valid[idx] && (m_tag[idx] == a[31:10]);
        exp_stall = hit ? 0 : (2 + mem_lat + (m_dirty[idx] ? mem_lat : 0));
        bus.cpu_addr_i = a;
        bus.cpu_data_i = d;
        bus.cpu_MemRead_i = rd;
        bus.cpu_MemWrite_i = wr;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (!bus.cpu_stall_o) break;
            cyc++;
            if (cyc > 200) break;
        end
        last_rdata = bus.cpu_data_o;
        chk("stall_cycles", LINE_W'(cyc), LINE_W'(exp_stall));
        @(posedge clk);
        #1;
        bus.cpu_MemRead_i = 1'b0;
        bus.cpu_MemWrite_i = 1'b0;
        m_valid[idx] = 1'b1;
        m_tag[idx] = a[31:10];
        if (wr) m_dirty[idx] = 1'b1;
        else if (!hit) m_dirty[idx] = 1'b0;
    endtask

    initial begin
        int wb0;
        bus.cpu_addr_i = '0;
        bus.cpu_data_i = '0;
        bus.cpu_MemRead_i = 1'b0;
        bus.cpu_MemWrite_i = 1'b0;
        bus.mem_ack_i = 1'b0;
        bus.mem_data_i = '0;
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = '0;
        end
        #12;
        chk("rst_stall",  {255'd0, bus.cpu_stall_o},  '0);
        chk("rst_enable", {255'd0, bus.mem_enable_o}, '0);
        chk("rst_write",  {255'd0, bus.mem_write_o},  '0);
        chk("rst_addr",   {224'd0, bus.mem_addr_o},   '0);
        chk("rst_mdata",  bus.mem_data_o,             '0);
        chk("rst_cdata",  {224'd0, bus.cpu_data_o},   '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Cold load miss, then a word-2 hit of the same line.
        access(1, 0, 32'h40, 0);
        chk("t1_word0", {224'd0, last_rdata}, {224'd0, 32'hA000_0040});
        chk("t1_no_wb", LINE_W'(wb_count), '0);
        chk("t1_rdaddr", {224'd0, last_rd_addr}, {224'd0, 32'h40});
        access(1, 0, 32'h48, 0);
        chk("t1_word2", {224'd0, last_rdata}, {224'd0, 32'hA000_0048});

        access(0, 1, 32'h44, 32'hDEAD_BEEF);
        access(1, 0, 32'h44, 0);
        chk("t2_load", {224'd0, last_rdata}, {224'd0, 32'hDEAD_BEEF});

        // Conflict miss on index 2 with a dirty victim.
        access(1, 0, 32'h440, 0);
        chk("t3_wbcnt", LINE_W'(wb_count), LINE_W'(1));
        chk("t3_wbaddr", {224'd0, last_wb_addr}, {224'd0, 32'h40});
        chk("t3_wbword1", {224'd0, last_wb_line[63:32]}, {224'd0, 32'hDEAD_BEEF});
        chk("t3_rdaddr", {224'd0, last_rd_addr}, {224'd0, 32'h440});
        chk("t3_load", {224'd0, last_rdata}, {224'd0, 32'hA000_0440});

        wb0 = wb_count;
        access(0, 1, 32'h8C4, 32'h1234_5678);
        chk("t4_no_wb", LINE_W'(wb_count), LINE_W'(wb0));
        access(1, 0, 32'h8C4, 0);
        chk("t4_merged", {224'd0, last_rdata}, {224'd0, 32'h1234_5678});
        access(1, 0, 32'h8C0, 0);
        access(1, 0, 32'h0C4, 0);
        chk("t4_dirty_wb", {224'd0, last_wb_addr}, {224'd0, 32'h8C0});

        // Highest index and tag: clean store miss then readback.
        access(0, 1, 32'hFFFF_FFFC, 32'h5A5A_0001);
        access(1, 0, 32'hFFFF_FFFC, 0);
        chk("edge_load", {224'd0, last_rdata}, {224'd0, 32'h5A5A_0001});

        // Reset during a slow refill.
        mem_lat = 20;
        bus.cpu_addr_i = 32'h1000;
        bus.cpu_MemRead_i = 1'b1;
        repeat (4) @(negedge clk);
        chk("t5_in_alloc", {255'd0, bus.mem_enable_o}, {255'd0, 1'b1});
        #2 rst_n = 1'b0;
        #1;
        chk("t5_enable", {255'd0, bus.mem_enable_o}, '0);
        chk("t5_stall",  {255'd0, bus.cpu_stall_o},  '0);
        chk("t5_cdata",  {224'd0, bus.cpu_data_o},   '0);
        bus.cpu_MemRead_i = 1'b0;
        golden.delete();
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0; m_dirty[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mem_lat = 3;
        @(posedge clk); #1;
        access(1, 0, 32'h1000, 0);
        access(1, 0, 32'h44, 0);
        chk("t5_backing", {224'd0, last_rdata}, {224'd0, 32'hDEAD_BEEF});

        // Both request lines high on a hit behave as a store.
        access(1, 1, 32'h44, 32'hCAFE_F00D);
        access(1, 0, 32'h44, 0);
        chk("t6_store", {224'd0, last_rdata}, {224'd0, 32'hCAFE_F00D});

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation limit reached");
        $fatal(1, "timeout");
    end
endmodule
